apb_cmd_issuer: RTL
===================

APB_CMD_ISSUER -- requirements
Module: apb_cmd_issuer

Interface
REQ-001 SHALL have parameters: DEPTH, default 4, command FIFO entries; TIMEOUT, default 32, maximum BUSY cycles before abort.
REQ-002 SHALL have ports:
- clk  input  1  sole clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command accepted when high with cmd_valid.
- cmd_wr  input  1  1 = write, 0 = read.
- cmd_addr  input  4  target address.
- cmd_data  input  8  write data; ignored for reads.
- newd  output  1  transfer request to the APB master.
- wr  output  1  direction to the APB master.
- ain  output  4  address to the APB master.
- din  output  8  write data to the APB master.
- xfer_done  input  1  one-cycle pulse from the APB master at transfer completion.
- rdata  input  8  read data from the APB master, valid with xfer_done.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_wr, rsp_addr[3:0], rsp_data[7:0], rsp_err  output  echo of command, read data, timeout flag.
- busy  output  1  FIFO non-empty or state != IDLE.

Function
REQ-003 SHALL buffer commands in an in-order FIFO of DEPTH entries; push on cmd_valid && cmd_ready.
- 2-bit pointers wrap modulo DEPTH.
- Occupancy count ranges 0..DEPTH.
REQ-004 SHALL drive cmd_ready = !full && !rst; a command offered while full SHALL be held off, not dropped.
REQ-005 SHALL implement FSM IDLE, BUSY, RESP.
REQ-006 IDLE with FIFO non-empty SHALL pop the head into holding registers and go to BUSY; the FIFO has no fall-through, so a command pushed at edge T is popped at edge T+1 at earliest.
REQ-007 BUSY SHALL drive newd=1 and drive wr/ain/din from the holding registers, all stable for the whole state.
REQ-008 BUSY SHALL clear a 5-bit cycle counter on entry and increment it each BUSY cycle.
REQ-009 In BUSY, xfer_done=1 SHALL go to RESP, capturing rdata for reads (rsp_data = 0 for writes) and setting rsp_err=0.
REQ-010 In BUSY, counter == TIMEOUT-1 with xfer_done=0 SHALL go to RESP with rsp_err=1 and rsp_data=0.
REQ-011 xfer_done and timeout in the same cycle SHALL resolve as completion (err=0).
REQ-012 RESP SHALL assert rsp_valid for exactly one cycle with newd=0, then go to IDLE.
- Consequence: newd is low for at least 2 cycles between consecutive transfers.
REQ-013 xfer_done outside BUSY SHALL be ignored.
REQ-014 When not in BUSY, outputs newd/wr/ain/din SHALL be 0.
REQ-015 A push and a pop in the same cycle SHALL leave occupancy unchanged.
REQ-016 Responses SHALL come out in command order, one per accepted command.

Reset
REQ-017 rst=1 at an edge SHALL set state IDLE and empty the FIFO.
- Outputs 0: newd, wr, ain, din, rsp_valid, rsp_wr, rsp_addr, rsp_data, rsp_err, busy.
- Counter cleared.
REQ-018 Reset during BUSY or RESP SHALL discard the in-flight command with no response; newd is low from the following cycle.
REQ-019 cmd_ready SHALL be 0 while rst=1 and 1 in the first cycle after release.

Structure
REQ-020 Package apb_cmd_pkg SHALL hold the widths (ADDR_W=4, DATA_W=8), DEPTH/TIMEOUT defaults, the FSM state enum, and the command struct {wr, addr, data}.
REQ-021 The FIFO SHALL be sub-module apb_cmd_fifo (push/pop/full/empty/head); the FSM, holding registers and counter SHALL live in apb_cmd_issuer.

Verification
REQ-022 Write addr 3 data 0x07, xfer_done after 5 BUSY cycles -> newd high 5 cycles with ain=3 din=0x07 wr=1; next cycle rsp_valid with rsp_wr=1, rsp_addr=3, rsp_err=0.
REQ-023 Read addr 2, xfer_done with rdata=0xA5 -> rsp_data=0xA5, rsp_wr=0, rsp_err=0.
REQ-024 Push 6 commands back-to-back, xfer_done withheld -> first command issued, 4 buffered, cmd_ready low and 6th held; after done pulses, responses in push order.
REQ-025 No xfer_done -> newd high exactly 32 cycles, then rsp_valid with rsp_err=1, rsp_data=0; next queued command issues normally.
REQ-026 xfer_done on 32nd BUSY cycle -> rsp_err=0; separately, rst in BUSY -> newd=0 next cycle, no rsp_valid, busy=0, FIFO empty.

Source files
------------

// File: rtl/apb_cmd_pkg.sv
// Shared widths, defaults, FSM state encoding and command layout for the APB command issuer.
package apb_cmd_pkg;
    localparam int ADDR_W      = 4;
    localparam int DATA_W      = 8;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_TIMEOUT = 32;
    localparam int CNT_W       = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;
endpackage

// File: rtl/apb_cmd_fifo.sv
// In-order command FIFO, registered storage with no fall-through; head is valid while not empty.
module apb_cmd_fifo
    import apb_cmd_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  logic i_pop,
    input  cmd_t i_wdata,
    output logic o_full,
    output logic o_empty,
    output cmd_t o_head
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    cmd_t             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    // Explicit wrap keeps non-power-of-two depths in range.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full  = (r_count == OCC_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end
endmodule

// File: rtl/apb_cmd_issuer.sv
// Queues read/write commands and issues them one at a time to an APB master,
// returning one response per command with a timeout abort.
module apb_cmd_issuer
    import apb_cmd_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              newd,
    output logic              wr,
    output logic [ADDR_W-1:0] ain,
    output logic [DATA_W-1:0] din,
    input  logic              xfer_done,
    input  logic [DATA_W-1:0] rdata,
    output logic              rsp_valid,
    output logic              rsp_wr,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy
);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_e            r_state;
    state_e            w_state_nxt;
    cmd_t              r_hold;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_rsp_wr;
    logic [ADDR_W-1:0] r_rsp_addr;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_err;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_in_busy;
    logic              w_timeout;
    cmd_t              w_head;
    cmd_t              w_cmd_in;

    assign w_cmd_in  = '{wr: cmd_wr, addr: cmd_addr, data: cmd_data};
    assign cmd_ready = !w_full && !rst;

    apb_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (cmd_valid && cmd_ready),
        .i_pop   (w_pop),
        .i_wdata (w_cmd_in),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    assign w_in_busy = (r_state == ST_BUSY);
    assign w_timeout = (r_cnt == TO_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (xfer_done || w_timeout) w_state_nxt = ST_RESP;
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_hold     <= '0;
            r_cnt      <= '0;
            r_rsp_wr   <= 1'b0;
            r_rsp_addr <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                r_hold <= w_head;
                r_cnt  <= '0;
            end
            if (w_in_busy) begin
                r_cnt <= r_cnt + 1'b1;
                // Completion wins over a simultaneous timeout.
                if (xfer_done) begin
                    r_rsp_wr   <= r_hold.wr;
                    r_rsp_addr <= r_hold.addr;
                    r_rsp_data <= r_hold.wr ? '0 : rdata;
                    r_rsp_err  <= 1'b0;
                end else if (w_timeout) begin
                    r_rsp_wr   <= r_hold.wr;
                    r_rsp_addr <= r_hold.addr;
                    r_rsp_data <= '0;
                    r_rsp_err  <= 1'b1;
                end
            end
        end
    end

    assign newd      = w_in_busy;
    assign wr        = w_in_busy && r_hold.wr;
    assign ain       = w_in_busy ? r_hold.addr : '0;
    assign din       = w_in_busy ? r_hold.data : '0;
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_wr    = r_rsp_wr;
    assign rsp_addr  = r_rsp_addr;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign busy      = !w_empty || (r_state != ST_IDLE);
endmodule
